// File: rtl/viterbi_ber_checker.sv
`timescale 1ns/1ps
// viterbi_ber_checker: receive-side bit-error monitor. Source information bits
// are queued in an alignment FIFO and compared, in order, against the bits
// emerging from the Viterbi decoder. It reports the checked-bit count, the
// error count, the longest error burst and sticky FIFO alignment faults.
module viterbi_ber_checker #(
    parameter int DEPTH   = 64,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         cfg_skip,
    input  logic [CNT_W-1:0]   cfg_num_bits,
    input  logic               src_valid,
    input  logic               src_bit,
    input  logic               dec_valid,
    input  logic               dec_bit,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   bits_checked,
    output logic [CNT_W-1:0]   bit_errors,
    output logic [BURST_W-1:0] max_burst,
    output logic               err_pulse,
    output logic               overflow,
    output logic               underflow,
    output logic               done
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SKIP  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0]        PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [7:0]         skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0]   num_bits_q, num_bits_d;
    logic [CNT_W-1:0]   bits_checked_q, bits_checked_d;
    logic [CNT_W-1:0]   bit_errors_q, bit_errors_d;
    logic [BURST_W-1:0] max_burst_q, max_burst_d;
    logic [BURST_W-1:0] cur_burst_q, cur_burst_d;
    logic               err_pulse_q, err_pulse_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               mem_q [DEPTH];

    logic               fifo_empty;
    logic               fifo_full;
    logic               active;
    logic               pop_ok;
    logic               push_ok;
    logic               head_bit;
    logic [BURST_W-1:0] burst_inc;

    // FIFO status and the push/pop handshakes; start takes priority and blocks both
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        active     = (state_q == S_SKIP) || (state_q == S_CHECK);
        pop_ok     = active && !start && dec_valid && !fifo_empty;
        push_ok    = active && !start && src_valid && (!fifo_full || pop_ok);
        head_bit   = mem_q[rd_ptr_q[AW-1:0]];
        burst_inc  = (&cur_burst_q) ? cur_burst_q : cur_burst_q + BURST_ONE;
    end

    // Next-state logic for the run FSM, FIFO pointers and saturating statistics
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        skip_cnt_d     = skip_cnt_q;
        num_bits_d     = num_bits_q;
        bits_checked_d = bits_checked_q;
        bit_errors_d   = bit_errors_q;
        max_burst_d    = max_burst_q;
        cur_burst_d    = cur_burst_q;
        err_pulse_d    = 1'b0;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;

        if (start) begin
            state_d        = (cfg_skip == 8'd0) ? S_CHECK : S_SKIP;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            skip_cnt_d     = cfg_skip;
            num_bits_d     = cfg_num_bits;
            bits_checked_d = '0;
            bit_errors_d   = '0;
            max_burst_d    = '0;
            cur_burst_d    = '0;
            overflow_d     = 1'b0;
            underflow_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (active && src_valid && fifo_full && !pop_ok) begin
                overflow_d = 1'b1;
            end
            if (active && dec_valid && fifo_empty) begin
                underflow_d = 1'b1;
            end

            if (state_q == S_SKIP && pop_ok) begin
                skip_cnt_d = skip_cnt_q - 8'd1;
                if (skip_cnt_q == 8'd1) begin
                    state_d = S_CHECK;
                end
            end

            if (state_q == S_CHECK && pop_ok) begin
                if (!(&bits_checked_q)) begin
                    bits_checked_d = bits_checked_q + CNT_ONE;
                end
                if (dec_bit != head_bit) begin
                    err_pulse_d = 1'b1;
                    if (!(&bit_errors_q)) begin
                        bit_errors_d = bit_errors_q + CNT_ONE;
                    end
                    cur_burst_d = burst_inc;
                    if (burst_inc > max_burst_q) begin
                        max_burst_d = burst_inc;
                    end
                end else begin
                    cur_burst_d = '0;
                end
                if (num_bits_q != '0 && bits_checked_d == num_bits_q) begin
                    state_d = S_DONE;
                end
            end
        end
    end

    // State and statistics registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            skip_cnt_q     <= '0;
            num_bits_q     <= '0;
            bits_checked_q <= '0;
            bit_errors_q   <= '0;
            max_burst_q    <= '0;
            cur_burst_q    <= '0;
            err_pulse_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            skip_cnt_q     <= skip_cnt_d;
            num_bits_q     <= num_bits_d;
            bits_checked_q <= bits_checked_d;
            bit_errors_q   <= bit_errors_d;
            max_burst_q    <= max_burst_d;
            cur_burst_q    <= cur_burst_d;
            err_pulse_q    <= err_pulse_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= src_bit;
        end
    end

    assign state_o      = state_q;
    assign bits_checked = bits_checked_q;
    assign bit_errors   = bit_errors_q;
    assign max_burst    = max_burst_q;
    assign err_pulse    = err_pulse_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_viterbi_ber_checker.sv
`timescale 1ns/1ps
// tb_viterbi_ber_checker: drives source and decoder bit streams into the BER
// checker. Expected error pulses are queued as the decoder bits are driven and
// consumed when the DUT raises err_pulse; run totals come from a bench model.
module tb_viterbi_ber_checker;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;
    localparam int SMALL_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         cfg_skip = 8'd0;
    logic [CNT_W-1:0]   cfg_num_bits = '0;
    logic               src_valid = 1'b0;
    logic               src_bit = 1'b0;
    logic               dec_valid = 1'b0;
    logic               dec_bit = 1'b0;

    logic [1:0]         state_o;
    logic [CNT_W-1:0]   bits_checked;
    logic [CNT_W-1:0]   bit_errors;
    logic [BURST_W-1:0] max_burst;
    logic               err_pulse;
    logic               overflow;
    logic               underflow;
    logic               done;

    logic [1:0]         sState;
    logic [SMALL_W-1:0] sBitsChecked;
    logic [SMALL_W-1:0] sBitErrors;
    logic [BURST_W-1:0] sMaxBurst;
    logic               sErrPulse;
    logic               sOverflow;
    logic               sUnderflow;
    logic               sDone;

    logic srcArr  [512];
    logic decArr  [512];
    logic errMask [512];
    int   expPulseQ [$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   cycle = 0;
    int   expErrs;
    int   expBurst;

    viterbi_ber_checker #(.DEPTH(64), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_skip(cfg_skip),
        .cfg_num_bits(cfg_num_bits), .src_valid(src_valid), .src_bit(src_bit),
        .dec_valid(dec_valid), .dec_bit(dec_bit), .state_o(state_o),
        .bits_checked(bits_checked), .bit_errors(bit_errors), .max_burst(max_burst),
        .err_pulse(err_pulse), .overflow(overflow), .underflow(underflow), .done(done)
    );

    viterbi_ber_checker #(.DEPTH(64), .CNT_W(SMALL_W), .BURST_W(BURST_W)) dutSmall (
        .clk(clk), .rst(rst), .start(start), .cfg_skip(cfg_skip),
        .cfg_num_bits(cfg_num_bits[SMALL_W-1:0]), .src_valid(src_valid), .src_bit(src_bit),
        .dec_valid(dec_valid), .dec_bit(dec_bit), .state_o(sState),
        .bits_checked(sBitsChecked), .bit_errors(sBitErrors), .max_burst(sMaxBurst),
        .err_pulse(sErrPulse), .overflow(sOverflow), .underflow(sUnderflow), .done(sDone)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected error pulses
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Every err_pulse must match the oldest queued expectation and arrive on the predicted cycle
    always @(negedge clk) begin
        int expCyc;
        if (err_pulse) begin
            if (expPulseQ.size() == 0) begin
                checkOutput("errPulseUnexpected", 1, 0);
            end else begin
                expCyc = expPulseQ.pop_front();
                checkOutput("errPulseCycle", cycle, expCyc);
            end
        end
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic startRun(input int skipN, input int numBits);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_skip = 8'(skipN);
        cfg_num_bits = CNT_W'(numBits);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearMask();
        for (int i = 0; i < 512; i++) errMask[i] = 1'b0;
    endtask

    // Random source bits; decoder bits are garbage while skipping, then the source bits with masked inversions
    task automatic buildStream(input int n, input int skipN);
        for (int d = 0; d < n; d++) begin
            srcArr[d] = 1'($urandom_range(1, 0));
            if (d < skipN) decArr[d] = 1'($urandom_range(1, 0));
            else           decArr[d] = srcArr[d] ^ errMask[d];
        end
    endtask

    // Independent model of the error count and longest burst over the compared window
    task automatic computeExpect(input int skipN, input int nCmp, output int errs, output int burst);
        int run;
        run = 0; errs = 0; burst = 0;
        for (int d = skipN; d < skipN + nCmp; d++) begin
            if (errMask[d]) begin
                run++; errs++;
                if (run > burst) burst = run;
            end else begin
                run = 0;
            end
        end
    endtask

    // Drive source bits from cycle 0 and decoder bits from cycle 'delay'; queue expected pulses
    task automatic applyStimulus(input int nSrc, input int nDec, input int delay, input int skipN);
        int total;
        int d;
        total = (nSrc > delay + nDec) ? nSrc : delay + nDec;
        for (int t = 0; t < total; t++) begin
            @(posedge clk); #1;
            src_valid = (t < nSrc);
            src_bit   = (t < nSrc) ? srcArr[t] : 1'b0;
            d = t - delay;
            if (d >= 0 && d < nDec) begin
                dec_valid = 1'b1;
                dec_bit   = decArr[d];
                if (d >= skipN && errMask[d]) expPulseQ.push_back(cycle + 1);
            end else begin
                dec_valid = 1'b0;
                dec_bit   = 1'b0;
            end
        end
        @(posedge clk); #1;
        src_valid = 1'b0; src_bit = 1'b0; dec_valid = 1'b0; dec_bit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic endTest(input string tag);
        checkOutput(tag, expPulseQ.size(), 0);
        expPulseQ.delete();
    endtask

    // Main test sequence
    initial begin
        clearMask();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstState", state_o, 0);
        checkOutput("rstBits", bits_checked, 0);
        checkOutput("rstErrors", bit_errors, 0);
        checkOutput("rstBurst", max_burst, 0);
        checkOutput("rstPulse", err_pulse, 0);
        checkOutput("rstOverflow", overflow, 0);
        checkOutput("rstUnderflow", underflow, 0);
        checkOutput("rstDone", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] error-free run");
        clearMask();
        buildStream(256, 0);
        startRun(0, 256);
        checkOutput("cleanStartState", state_o, 2);
        applyStimulus(256, 256, 20, 0);
        checkOutput("cleanBits", bits_checked, 256);
        checkOutput("cleanErrors", bit_errors, 0);
        checkOutput("cleanBurst", max_burst, 0);
        checkOutput("cleanDone", done, 1);
        checkOutput("cleanState", state_o, 3);
        checkOutput("cleanOverflow", overflow, 0);
        checkOutput("cleanUnderflow", underflow, 0);
        endTest("cleanPulsesMissing");

        $display("[TB] periodic errors");
        clearMask();
        for (int i = 0; i < 256; i++) errMask[i] = ((i % 8) == 7);
        buildStream(256, 0);
        computeExpect(0, 256, expErrs, expBurst);
        startRun(0, 256);
        applyStimulus(256, 256, 20, 0);
        checkOutput("periodicBits", bits_checked, 256);
        checkOutput("periodicErrors", bit_errors, expErrs);
        checkOutput("periodicBurst", max_burst, expBurst);
        checkOutput("periodicDone", done, 1);
        endTest("periodicPulsesMissing");

        $display("[TB] skip and burst");
        clearMask();
        for (int i = 45; i <= 48; i++) errMask[i] = 1'b1;
        buildStream(105, 5);
        computeExpect(5, 100, expErrs, expBurst);
        startRun(5, 100);
        checkOutput("skipStartState", state_o, 1);
        applyStimulus(105, 105, 10, 5);
        checkOutput("skipBits", bits_checked, 100);
        checkOutput("skipErrors", bit_errors, expErrs);
        checkOutput("skipBurst", max_burst, expBurst);
        checkOutput("skipDone", done, 1);
        endTest("skipPulsesMissing");

        $display("[TB] overflow then underflow");
        clearMask();
        buildStream(65, 0);
        startRun(0, 0);
        applyStimulus(65, 64, 65, 0);
        checkOutput("ovfFlag", overflow, 1);
        checkOutput("ovfHeldBits", bits_checked, 64);
        checkOutput("ovfErrors", bit_errors, 0);
        checkOutput("ovfNoUnderflow", underflow, 0);
        @(posedge clk); #1;
        dec_valid = 1'b1; dec_bit = 1'b1;
        @(posedge clk); #1;
        dec_valid = 1'b0; dec_bit = 1'b0;
        @(negedge clk);
        checkOutput("unfFlag", underflow, 1);
        checkOutput("unfBitsUnchanged", bits_checked, 64);
        checkOutput("unfErrorsUnchanged", bit_errors, 0);
        endTest("ovfPulsesMissing");

        $display("[TB] push and pop at full");
        clearMask();
        buildStream(65, 0);
        startRun(0, 0);
        applyStimulus(65, 65, 64, 0);
        checkOutput("fullPpOverflow", overflow, 0);
        checkOutput("fullPpBits", bits_checked, 65);
        checkOutput("fullPpErrors", bit_errors, 0);
        checkOutput("fullPpUnderflow", underflow, 0);
        endTest("fullPpPulsesMissing");

        $display("[TB] restart mid-check");
        clearMask();
        errMask[10] = 1'b1; errMask[11] = 1'b1; errMask[30] = 1'b1;
        buildStream(50, 0);
        computeExpect(0, 50, expErrs, expBurst);
        startRun(0, 0);
        applyStimulus(50, 50, 2, 0);
        checkOutput("preRestartBits", bits_checked, 50);
        checkOutput("preRestartErrors", bit_errors, expErrs);
        checkOutput("preRestartBurst", max_burst, expBurst);
        endTest("preRestartPulsesMissing");
        startRun(3, 20);
        checkOutput("restartState", state_o, 1);
        checkOutput("restartBits", bits_checked, 0);
        checkOutput("restartErrors", bit_errors, 0);
        checkOutput("restartBurst", max_burst, 0);
        checkOutput("restartDone", done, 0);
        clearMask();
        buildStream(23, 3);
        applyStimulus(23, 23, 2, 3);
        checkOutput("postRestartBits", bits_checked, 20);
        checkOutput("postRestartErrors", bit_errors, 0);
        checkOutput("postRestartDone", done, 1);
        startRun(0, 0);
        checkOutput("restartNoSkipState", state_o, 2);
        endTest("restartPulsesMissing");

        $display("[TB] reset mid-check");
        clearMask();
        errMask[5] = 1'b1; errMask[6] = 1'b1; errMask[7] = 1'b1;
        buildStream(30, 0);
        startRun(0, 0);
        applyStimulus(30, 30, 3, 0);
        checkOutput("preRstErrors", bit_errors, 3);
        @(posedge clk); #1;
        dec_valid = 1'b1;
        @(posedge clk); #1;
        dec_valid = 1'b0;
        @(negedge clk);
        checkOutput("preRstUnderflow", underflow, 1);
        endTest("preRstPulsesMissing");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstState", state_o, 0);
        checkOutput("midRstBits", bits_checked, 0);
        checkOutput("midRstErrors", bit_errors, 0);
        checkOutput("midRstBurst", max_burst, 0);
        checkOutput("midRstPulse", err_pulse, 0);
        checkOutput("midRstUnderflow", underflow, 0);
        checkOutput("midRstOverflow", overflow, 0);
        checkOutput("midRstDone", done, 0);
        clearMask();
        buildStream(30, 0);
        startRun(0, 30);
        applyStimulus(30, 30, 4, 0);
        checkOutput("afterRstBits", bits_checked, 30);
        checkOutput("afterRstErrors", bit_errors, 0);
        checkOutput("afterRstDone", done, 1);
        endTest("afterRstPulsesMissing");

        $display("[TB] counter saturation");
        clearMask();
        for (int i = 0; i < 20; i++) errMask[i] = 1'b1;
        buildStream(20, 0);
        computeExpect(0, 20, expErrs, expBurst);
        startRun(0, 0);
        applyStimulus(20, 20, 1, 0);
        checkOutput("satMainBits", bits_checked, 20);
        checkOutput("satMainErrors", bit_errors, expErrs);
        checkOutput("satMainBurst", max_burst, expBurst);
        checkOutput("satSmallErrors", sBitErrors, 15);
        checkOutput("satSmallBits", sBitsChecked, 15);
        checkOutput("satSmallBurst", sMaxBurst, expBurst);
        endTest("satPulsesMissing");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
